// File: rtl/branch_stall_ctrl_if.sv
// branch_stall_ctrl_if: groups the branch stall controller's pipeline-side
// inputs (IF/ID instruction, ID/EX handshake, EX resolution) and its
// stall/bubble/redirect/timeout outputs.
// The slave modport is the controller's view and the master modport is the pipeline's view.
// Optional macro BRANCH_STALL_PERF_EN adds the 32-bit stall cycle counter output.
interface branch_stall_ctrl_if #(
  parameter int PC_W = 32
) ();

  logic [31:0]     branchctrlin_inst;
  logic            branchctrlin_inst_valid;
  logic            branchctrlin_id_ready;
  logic            branchctrlin_resolve_valid;
  logic            branchctrlin_resolve_taken;
  logic [PC_W-1:0] branchctrlin_resolve_target;

  logic            branchctrlout_stall_if;
  logic            branchctrlout_bubble_id;
  logic            branchctrlout_redirect_valid;
  logic [PC_W-1:0] branchctrlout_redirect_pc;
  logic            branchctrlout_timeout;
  logic            branchctrlout_busy;
`ifdef BRANCH_STALL_PERF_EN
  logic [31:0]     branchctrlout_stall_cycles;
`endif

  // Controller side
  modport slave (
    input  branchctrlin_inst,
    input  branchctrlin_inst_valid,
    input  branchctrlin_id_ready,
    input  branchctrlin_resolve_valid,
    input  branchctrlin_resolve_taken,
    input  branchctrlin_resolve_target,
    output branchctrlout_stall_if,
    output branchctrlout_bubble_id,
    output branchctrlout_redirect_valid,
    output branchctrlout_redirect_pc,
    output branchctrlout_timeout,
    output branchctrlout_busy
`ifdef BRANCH_STALL_PERF_EN
    , output branchctrlout_stall_cycles
`endif
  );

  // Pipeline side
  modport master (
    output branchctrlin_inst,
    output branchctrlin_inst_valid,
    output branchctrlin_id_ready,
    output branchctrlin_resolve_valid,
    output branchctrlin_resolve_taken,
    output branchctrlin_resolve_target,
    input  branchctrlout_stall_if,
    input  branchctrlout_bubble_id,
    input  branchctrlout_redirect_valid,
    input  branchctrlout_redirect_pc,
    input  branchctrlout_timeout,
    input  branchctrlout_busy
`ifdef BRANCH_STALL_PERF_EN
    , input branchctrlout_stall_cycles
`endif
  );

endinterface

// File: rtl/branch_stall_ctrl.sv
// branch_stall_ctrl: holds the front end while a decoded branch/jal/jalr waits
// for EX resolution, then issues a one-cycle PC redirect when the transfer is taken.
// The controller gives up after MAX_WAIT cycles in WAIT (legal range 1..15) and raises a one-cycle timeout strobe.
// All outputs come straight from flops.
// Optional macro BRANCH_STALL_PERF_EN adds a saturating count of stalled cycles.
module branch_stall_ctrl #(
  parameter int MAX_WAIT = 4,
  parameter int PC_W     = 32
) (
  input logic               clk,
  input logic               rstn,
  branch_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Last counter value before the held branch is abandoned.
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  // Branch (1100011), jal (1101111) and jalr (1100111) are control transfers.
  function automatic logic is_ctrl_xfer(input logic [6:0] opcode);
    logic hit;
    case (opcode)
      7'b1100011: hit = 1'b1;
      7'b1101111: hit = 1'b1;
      7'b1100111: hit = 1'b1;
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] target_q, target_d;
  logic            timeout_d;
  logic            stall_q;
  logic            redirect_valid_q;
  logic            timeout_q;
  logic            busy_q;
  logic            ctrl_xfer_s;
  logic            unused_inst_s;

  assign ctrl_xfer_s   = is_ctrl_xfer(bus.branchctrlin_inst[6:0]);
  assign unused_inst_s = ^bus.branchctrlin_inst[31:7];

  // Next-state, wait counter, target latch and timeout strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.branchctrlin_inst_valid && bus.branchctrlin_id_ready && ctrl_xfer_s) begin
          state_d = ST_WAIT;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Resolution wins over the timeout on the last wait cycle.
        if (bus.branchctrlin_resolve_valid) begin
          cnt_d = 4'd0;
          if (bus.branchctrlin_resolve_taken) begin
            state_d  = ST_REDIRECT;
            target_d = bus.branchctrlin_resolve_target;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == WAIT_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = 4'd0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter, target and registered Moore outputs derived from next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 4'd0;
      target_q         <= '0;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      timeout_q        <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      target_q         <= target_d;
      stall_q          <= (state_d != ST_IDLE);
      redirect_valid_q <= (state_d == ST_REDIRECT);
      timeout_q        <= timeout_d;
      busy_q           <= (state_d != ST_IDLE);
    end
  end

  assign bus.branchctrlout_stall_if       = stall_q;
  assign bus.branchctrlout_bubble_id      = stall_q;
  assign bus.branchctrlout_redirect_valid = redirect_valid_q;
  assign bus.branchctrlout_redirect_pc    = target_q;
  assign bus.branchctrlout_timeout        = timeout_q;
  assign bus.branchctrlout_busy           = busy_q;

`ifdef BRANCH_STALL_PERF_EN
  logic [31:0] stall_cycles_q;

  // Saturating count of cycles in which stall_if is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles_q <= 32'd0;
    end else if (stall_q && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_q <= stall_cycles_q;
    end
  end

  assign bus.branchctrlout_stall_cycles = stall_cycles_q;
`endif

endmodule
